// File: rtl/decoder_pipe.sv
// Flow-controlled instruction decoder: decodes at the input, then buffers the
// decoded entry in an output register backed by a single skid entry.
module decoder_pipe #(
  parameter int INSTR_W   = 8,
  parameter int REG_SEL_W = 1,
  parameter int OPND_W    = INSTR_W - 3 - REG_SEL_W,
  parameter int COUNT_W   = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 ena,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTR_W-1:0]   instr_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2:0]           alu_opcode,
  output logic [REG_SEL_W-1:0] reg_sel,
  output logic [OPND_W-1:0]    operand,
  output logic                 alu_enable,
  output logic                 write_enable,
  output logic                 illegal,
  output logic [COUNT_W-1:0]   decode_count
);

  if (OPND_W < 1) begin : g_bad_opnd_w
    $error("decoder_pipe: OPND_W must be >= 1");
  end

  typedef struct packed {
    logic [2:0]           op;
    logic [REG_SEL_W-1:0] rsel;
    logic [OPND_W-1:0]    opnd;
    logic                 alu_en;
    logic                 wr_en;
    logic                 ill;
  } entry_t;

  entry_t dec;
  entry_t out_q;
  entry_t skid_q;
  logic   out_v;
  logic   skid_v;
  logic   accept;
  logic   drain;

  always_comb begin
    dec        = '0;
    dec.op     = instr_in[INSTR_W-1 -: 3];
    dec.rsel   = instr_in[OPND_W +: REG_SEL_W];
    dec.opnd   = instr_in[OPND_W-1:0];
    unique case (dec.op)
      3'b101:  dec.alu_en = 1'b1;
      3'b110:  dec.wr_en  = 1'b1;
      3'b111:  dec.ill    = |instr_in[INSTR_W-4:0];
      default: begin
        dec.alu_en = 1'b1;
        dec.wr_en  = 1'b1;
      end
    endcase
  end

  // ena gates both handshakes, so a frozen stage can neither accept nor drain
  assign in_ready  = ena & ~skid_v;
  assign out_valid = ena & out_v;
  assign accept    = in_valid & in_ready & ~flush;
  assign drain     = out_valid & out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_q  <= '0;
      out_v  <= 1'b0;
      skid_q <= '0;
      skid_v <= 1'b0;
    end else if (flush) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (drain) begin
      if (skid_v) begin
        out_q  <= skid_q;
        skid_v <= 1'b0;
      end else if (accept) begin
        out_q <= dec;
      end else begin
        out_v <= 1'b0;
      end
    end else if (accept) begin
      if (out_v) begin
        skid_q <= dec;
        skid_v <= 1'b1;
      end else begin
        out_q <= dec;
        out_v <= 1'b1;
      end
    end
  end

  // A handshake completing in a flush cycle still counts
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      decode_count <= '0;
    end else if (drain) begin
      decode_count <= decode_count + COUNT_W'(1);
    end
  end

  assign alu_opcode   = out_q.op;
  assign reg_sel      = out_q.rsel;
  assign operand      = out_q.opnd;
  assign alu_enable   = out_q.alu_en;
  assign write_enable = out_q.wr_en;
  assign illegal      = out_q.ill;

endmodule

// File: tb/tb_decoder_pipe.sv
// Bench for decoder_pipe: a 2-deep FIFO model checked every cycle, plus
// directed scenarios pinned with literal expectations.
module tb_decoder_pipe;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       ena = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] instr_in = '0;

  logic        in_ready, out_valid, alu_enable, write_enable, illegal;
  logic [2:0]  alu_opcode;
  logic [0:0]  reg_sel;
  logic [3:0]  operand;
  logic [15:0] decode_count;

  logic        in_ready4, out_valid4, alu_enable4, write_enable4, illegal4;
  logic [2:0]  alu_opcode4;
  logic [0:0]  reg_sel4;
  logic [3:0]  operand4;
  logic [3:0]  count4;

  decoder_pipe dut (
    .clock(clock), .reset_n(reset_n), .ena(ena), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instr_in(instr_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_opcode(alu_opcode), .reg_sel(reg_sel), .operand(operand),
    .alu_enable(alu_enable), .write_enable(write_enable), .illegal(illegal),
    .decode_count(decode_count)
  );

  decoder_pipe #(.COUNT_W(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .ena(ena), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4), .instr_in(instr_in),
    .out_valid(out_valid4), .out_ready(out_ready),
    .alu_opcode(alu_opcode4), .reg_sel(reg_sel4), .operand(operand4),
    .alu_enable(alu_enable4), .write_enable(write_enable4), .illegal(illegal4),
    .decode_count(count4)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {op, reg, opnd, alu_en, wr_en, illegal} straight from the decode table
  function automatic logic [10:0] expect_of(input logic [7:0] x);
    int op   = x / 32;
    int rs   = (x / 16) % 2;
    int opnd = x % 16;
    logic alu = 1'b0, wr = 1'b0, ill = 1'b0;
    if (op < 5) begin alu = 1'b1; wr = 1'b1; end
    else if (op == 5) alu = 1'b1;
    else if (op == 6) wr = 1'b1;
    else ill = (x % 32) != 0;
    return {op[2:0], rs[0], opnd[3:0], alu, wr, ill};
  endfunction

  logic [7:0] mq[$];
  int mcount = 0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      mcount = 0;
    end else begin
      bit acc, drn;
      drn = ena && mq.size() > 0 && out_ready;
      acc = in_valid && ena && mq.size() < 2 && !flush;
      if (drn) mcount++;
      if (flush) mq.delete();
      else begin
        if (drn) void'(mq.pop_front());
        if (acc) mq.push_back(instr_in);
      end
    end
  end

  always @(negedge clock) begin
    check("m_in_ready", in_ready, ena && mq.size() < 2);
    check("m_out_valid", out_valid, ena && mq.size() > 0);
    if (ena && mq.size() > 0)
      check("m_fields", {alu_opcode, reg_sel, operand, alu_enable, write_enable, illegal},
            expect_of(mq[0]));
    check("m_count", decode_count, mcount % 65536);
    check("m_count4", count4, mcount % 16);
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  logic [10:0] fields;
  assign fields = {alu_opcode, reg_sel, operand, alu_enable, write_enable, illegal};

  logic [7:0]  stream [6] = '{8'h03, 8'h35, 8'hA7, 8'hC9, 8'hE0, 8'hE1};
  logic [10:0] exp_s  [6] = '{11'b000_0_0011_110, 11'b001_1_0101_110, 11'b101_0_0111_100,
                              11'b110_0_1001_010, 11'b111_0_0000_000, 11'b111_0_0001_001};

  initial begin
    ena = 1'b1;
    #13 reset_n = 1'b1;
    cyc();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_count", decode_count, 0);
    check("rst_fields", fields, 0);

    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      instr_in = stream[i];
      cyc();
      check("stream_valid", out_valid, 1);
      check("stream_fields", fields, exp_s[i]);
    end
    in_valid = 1'b0;
    cyc();
    check("stream_count", decode_count, 6);
    check("stream_idle", out_valid, 0);

    out_ready = 1'b0;
    in_valid = 1'b1; instr_in = 8'h01;
    cyc();
    check("bp_ready_after_1", in_ready, 1);
    instr_in = 8'h02;
    cyc();
    check("bp_ready_fall", in_ready, 0);
    instr_in = 8'h03;
    cyc();
    cyc();
    check("bp_hold", operand, 1);
    out_ready = 1'b1;
    #1 check("drain_full_in_ready", in_ready, 0);
    cyc();
    check("bp_order2", operand, 2);
    check("bp_ready_back", in_ready, 1);
    cyc();
    check("bp_order3", operand, 3);
    in_valid = 1'b0;
    cyc();
    check("bp_empty", out_valid, 0);
    check("bp_count", decode_count, 9);

    out_ready = 1'b0;
    in_valid = 1'b1; instr_in = 8'h21;
    cyc();
    instr_in = 8'h42;
    cyc();
    in_valid = 1'b0;
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("ena_out_valid", out_valid, 0);
      check("ena_in_ready", in_ready, 0);
      check("ena_count", decode_count, 9);
    end
    ena = 1'b1;
    #1 check("ena_resume_21", fields, 11'b001_0_0001_110);
    check("ena_resume_valid", out_valid, 1);
    out_ready = 1'b1;
    cyc();
    check("ena_resume_42", fields, 11'b010_0_0010_110);
    cyc();
    check("ena_drained", out_valid, 0);
    check("ena_count_after", decode_count, 11);

    out_ready = 1'b0;
    in_valid = 1'b1; instr_in = 8'h11;
    cyc();
    instr_in = 8'h12;
    cyc();
    instr_in = 8'h55; flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("flush_no_55", out_valid, 0);
    end
    check("flush_count", decode_count, 11);

    for (int i = 0; i < 4000; i++) begin
      ena       = $urandom_range(0, 9) != 0;
      flush     = $urandom_range(0, 29) == 0;
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      instr_in  = 8'($urandom);
      cyc();
    end
    ena = 1'b1; flush = 1'b0;

    out_ready = 1'b0;
    in_valid = 1'b1; instr_in = 8'h77;
    cyc();
    instr_in = 8'h66;
    cyc();
    in_valid = 1'b0;
    check("pre_areset_valid", out_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    check("areset_out_valid", out_valid, 0);
    check("areset_fields", fields, 0);
    check("areset_count", decode_count, 0);
    check("areset_count4", count4, 0);
    check("areset_in_ready", in_ready, 1);
    #3 reset_n = 1'b1;
    cyc();

    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      instr_in = 8'($urandom);
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    check("wrap_count4", count4, 1);
    check("wrap_count16", decode_count, 17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
